// File: rtl/logic_gates_pipe.sv
// logic_gates_pipe
//   Registered bitwise gate unit. Each accepted beat computes op(a, b) over
//   WIDTH bits and queues the result in a 2-entry FIFO. The FIFO drains
//   through a valid/ready output port.
//
//   Optional feature macro: LOGIC_GATES_PIPE_REDUCE_EN
//     defined   - every entry also stores zero (~|y) and parity (^y),
//                 computed when the entry is written
//     undefined - zero and parity are tied low and no flag storage exists
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (registered count and rst_n only)
//   a, b       operands, WIDTH bits (b is ignored for NOT A / PASS A)
//   op         0 AND, 1 OR, 2 NOR, 3 XOR, 4 NAND, 5 XNOR, 6 NOT A, 7 PASS A
//   out_valid  head entry valid
//   out_ready  consumer accepts head entry
//   y          head entry result
//   zero       head result is all zeros (feature-gated)
//   parity     XOR-reduction of head result (feature-gated)
module logic_gates_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

`ifdef LOGIC_GATES_PIPE_REDUCE_EN
    localparam int EW = WIDTH + 2;
`else
    localparam int EW = WIDTH;
`endif

    logic [WIDTH-1:0] y_new;
    logic [EW-1:0]    entry_new;
    logic [EW-1:0]    entry0;     // head
    logic [EW-1:0]    entry1;     // second slot, only meaningful when count == 2
    logic [1:0]       count;
    logic             push;
    logic             pop;

    always_comb begin
        y_new = a;
        case (op)
            3'd0:    y_new = a & b;
            3'd1:    y_new = a | b;
            3'd2:    y_new = ~(a | b);
            3'd3:    y_new = a ^ b;
            3'd4:    y_new = ~(a & b);
            3'd5:    y_new = ~(a ^ b);
            3'd6:    y_new = ~a;
            default: y_new = a;
        endcase
    end

`ifdef LOGIC_GATES_PIPE_REDUCE_EN
    assign entry_new = {~|y_new, ^y_new, y_new};
`else
    assign entry_new = y_new;
`endif

    // rst_n is folded in so in_ready drops immediately on reset assertion.
    assign in_ready  = rst_n && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Shift-style FIFO: the head always lives in entry0, so y is a plain
    // register output with no read-pointer mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= entry_new;
                    else               entry1 <= entry_new;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                // Push and pop together only happen at count 1, so the new
                // beat replaces the head directly.
                2'b11: entry0 <= entry_new;
                default: ;
            endcase
        end
    end

    assign y = entry0[WIDTH-1:0];

`ifdef LOGIC_GATES_PIPE_REDUCE_EN
    assign zero   = entry0[WIDTH+1];
    assign parity = entry0[WIDTH];
`else
    assign zero   = 1'b0;
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_gates_pipe.sv
module tb_logic_gates_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, zero, parity;
    logic [7:0] a = '0, b = '0, y;
    logic [2:0] op = '0;

    // WIDTH=1 instance
    logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic       in_ready1, out_valid1, zero1, parity1;
    logic [0:0] a1 = '0, b1 = '0, y1;
    logic [2:0] op1 = '0;

    // WIDTH=64 instance
    logic        in_valid64 = 1'b0, out_ready64 = 1'b1;
    logic        in_ready64, out_valid64, zero64, parity64;
    logic [63:0] a64 = '0, b64 = '0, y64;
    logic [2:0]  op64 = '0;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [7:0] tt_exp [8] = '{8'hC0, 8'hFC, 8'h03, 8'h3C, 8'h3F, 8'hC3, 8'h0F, 8'hF0};

    logic_gates_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity));

    logic_gates_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
        .y(y1), .zero(zero1), .parity(parity1));

    logic_gates_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .op(op64), .out_valid(out_valid64), .out_ready(out_ready64),
        .y(y64), .zero(zero64), .parity(parity64));

    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return ~(x | z);
            3'd3: return x ^ z;
            3'd4: return ~(x & z);
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] r;
        logic        ez, ep;

        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_zero", zero, 0);
        chk("rst_parity", parity, 0);
        #20 rst_n = 1'b1;           // released between edges
        #1;
        chk("rel_in_ready", in_ready, 1);
        step();

        // ---------------- truth table, out_ready=1 ----------------
        out_ready = 1'b1;
        a = 8'hF0; b = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i); in_valid = 1'b1;
            chk($sformatf("tt_in_ready_%0d", i), in_ready, 1);
            step();
            chk($sformatf("tt_valid_%0d", i), out_valid, 1);
            chk($sformatf("tt_y_%0d", i), y, tt_exp[i]);
        end
        in_valid = 1'b0;
        step();
        chk("tt_drain", out_valid, 0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd3; a = 8'hAA; b = 8'h55;
        step();
        chk("bp_ready_after1", in_ready, 1);
        chk("bp_y1", y, 8'hFF);
        op = 3'd0; a = 8'hFF; b = 8'h0F;
        step();
        chk("bp_ready_full", in_ready, 0);
        op = 3'd1; a = 8'h00; b = 8'h00;
        step();
        chk("bp_held_ready", in_ready, 0);
        chk("bp_held_valid", out_valid, 1);
        chk("bp_held_y", y, 8'hFF);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_y", y, 8'h0F);
        chk("bp_pop1_ready", in_ready, 1);
        step();                      // third beat accepted, 8'h0F popped
        in_valid = 1'b0;
        chk("bp_pop2_y", y, 8'h00);
        chk("bp_pop2_valid", out_valid, 1);
        step();
        chk("bp_empty", out_valid, 0);

        // ---------------- push/pop at count 1 ----------------
        in_valid = 1'b1; op = 3'd7; b = 8'h00; a = 8'h11;
        step();
        for (int i = 0; i < 10; i++) begin
            a = 8'(8'h20 + i * 7);
            step();
            chk($sformatf("pp_valid_%0d", i), out_valid, 1);
            chk($sformatf("pp_ready_%0d", i), in_ready, 1);
            chk($sformatf("pp_y_%0d", i), y, 8'(8'h20 + i * 7));
        end
        in_valid = 1'b0;
        step();
        chk("pp_drain", out_valid, 0);

        // ---------------- reduction flags ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd0; a = 8'h0F; b = 8'hF0;
        step();
        in_valid = 1'b0;
`ifdef LOGIC_GATES_PIPE_REDUCE_EN
        ez = 1'b1; ep = 1'b0;
`else
        ez = 1'b0; ep = 1'b0;
`endif
        chk("fl_and_y", y, 8'h00);
        chk("fl_and_zero", zero, ez);
        chk("fl_and_parity", parity, ep);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd3; a = 8'h01; b = 8'h00;
        step();
        in_valid = 1'b0;
`ifdef LOGIC_GATES_PIPE_REDUCE_EN
        ez = 1'b0; ep = 1'b1;
`else
        ez = 1'b0; ep = 1'b0;
`endif
        chk("fl_xor_y", y, 8'h01);
        chk("fl_xor_zero", zero, ez);
        chk("fl_xor_parity", parity, ep);
        out_ready = 1'b1;
        step();
        chk("fl_drain", out_valid, 0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; a = 8'h12; b = 8'h40;
        step();
        a = 8'h34;
        step();
        in_valid = 1'b0;
        chk("mr_full", in_ready, 0);
        chk("mr_y_before", y, 8'h52);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_y", y, 0);
        chk("mr_in_ready", in_ready, 0);
        #3 rst_n = 1'b1;
        #1;
        chk("mr_rel_ready", in_ready, 1);
        step();
        chk("mr_no_stale", out_valid, 0);
        in_valid = 1'b1; op = 3'd4; a = 8'hFF; b = 8'hFF;
        step();
        in_valid = 1'b0;
        chk("mr_nand_valid", out_valid, 1);
        chk("mr_nand_y", y, 8'h00);
        chk("mr_one_entry", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("mr_drain", out_valid, 0);

        // ---------------- WIDTH=1 exhaustive ----------------
        for (int o = 0; o < 8; o++) begin
            for (int v = 0; v < 4; v++) begin
                in_valid1 = 1'b1; op1 = 3'(o);
                a1 = 1'(v >> 1); b1 = 1'(v);
                r = ref_op(3'(o), {63'd0, a1}, {63'd0, b1});
                step();
                chk($sformatf("w1_v_op%0d_%0d", o, v), out_valid1, 1);
                chk($sformatf("w1_y_op%0d_%0d", o, v), y1, r[0]);
            end
        end
        in_valid1 = 1'b0;
        step();
        chk("w1_drain", out_valid1, 0);

        // ---------------- WIDTH=64 random ----------------
        for (int o = 0; o < 8; o++) begin
            for (int k = 0; k < 4; k++) begin
                in_valid64 = 1'b1; op64 = 3'(o);
                a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
                r = ref_op(3'(o), a64, b64);
                step();
                chk($sformatf("w64_y_op%0d_%0d", o, k), y64, r);
            end
        end
        in_valid64 = 1'b0;
        step();
        chk("w64_drain", out_valid64, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
